// File: rtl/traffic_light_monitor_if.sv
// Lamp-bus interface between the traffic light controller side and the passive monitor.
// The master drives the lamps, the tick and the flag clear; the slave reports the decode and flags.
interface traffic_light_monitor_if;
    logic       tick;
    logic [2:0] light_i;
    logic       clr;
    logic [2:0] phase_o;
    logic       err_seq;
    logic       err_time;
    logic       err_code;
    logic       err_pulse;
    logic [7:0] cycle_count;

    modport master (
        output tick, light_i, clr,
        input  phase_o, err_seq, err_time, err_code, err_pulse, cycle_count
    );

    modport slave (
        input  tick, light_i, clr,
        output phase_o, err_seq, err_time, err_code, err_pulse, cycle_count
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the {red, yellow, green} lamp bus: decodes phases, measures dwell in ticks,
// and raises sticky flags for illegal codes, illegal successions and dwell-window violations.
module traffic_light_monitor #(
    parameter int TIME_RED    = 30,
    parameter int TIME_YELLOW = 3,
    parameter int TIME_GREEN  = 20,
    parameter int TOL         = 1,
    parameter int CW          = 8
) (
    input logic                    clk,
    input logic                    rst,
    traffic_light_monitor_if.slave bus
);

    typedef enum logic {StSync, StTrack} state_e;

    localparam logic [2:0] PhOff = 3'd0;
    localparam logic [2:0] PhR   = 3'd1;
    localparam logic [2:0] PhRy  = 3'd2;
    localparam logic [2:0] PhG   = 3'd3;
    localparam logic [2:0] PhY   = 3'd4;
    localparam logic [2:0] PhIll = 3'd7;

    localparam logic [CW-1:0] DwellMax = '1;

    function automatic logic [2:0] decode(input logic [2:0] l);
        case (l)
            3'b000:  return PhOff;
            3'b100:  return PhR;
            3'b110:  return PhRy;
            3'b001:  return PhG;
            3'b010:  return PhY;
            default: return PhIll;
        endcase
    endfunction

    function automatic int expected_t(input logic [2:0] ph);
        case (ph)
            PhR:       return TIME_RED;
            PhRy, PhY: return TIME_YELLOW;
            PhG:       return TIME_GREEN;
            default:   return 0;
        endcase
    endfunction

    function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
        return (to == PhOff) ||
               (from == PhOff && to == PhR)  || (from == PhR && to == PhRy) ||
               (from == PhRy  && to == PhG)  || (from == PhG && to == PhY)  ||
               (from == PhY   && to == PhR);
    endfunction

    function automatic logic out_of_window(input logic [2:0] ph, input logic [CW-1:0] dw);
        int d;
        d = int'(dw);
        return (d < expected_t(ph) - TOL) || (d > expected_t(ph) + TOL);
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    cycle_q, cycle_d;
    logic          seq_q, seq_d, time_q, time_d, code_q, code_d;
    logic          pulse_q, pulse_d;
    logic          new_seq, new_time, new_code;
    logic [2:0]    ph_new;
    logic          changed;

    assign ph_new  = decode(bus.light_i);
    assign changed = (ph_new != phase_q);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        dwell_d  = dwell_q;
        ovr_d    = ovr_q;
        cycle_d  = cycle_q;
        new_seq  = 1'b0;
        new_time = 1'b0;
        new_code = 1'b0;
        if (bus.tick) begin
            phase_d = ph_new;
            if (changed) begin
                dwell_d = CW'(1);
                ovr_d   = 1'b0;
            end else if (dwell_q != DwellMax) begin
                dwell_d = dwell_q + CW'(1);
            end
            if (ph_new == PhIll) begin
                new_code = 1'b1;
                state_d  = StSync;
            end else if (state_q == StSync) begin
                if (changed) state_d = StTrack;
            end else if (changed) begin
                // phase_q is never ILLEGAL while tracking, so it is a valid predecessor
                new_seq  = !legal_step(phase_q, ph_new);
                new_time = (phase_q != PhOff) && !ovr_q && out_of_window(phase_q, dwell_q);
                if (phase_q == PhY && ph_new == PhR) cycle_d = cycle_q + 8'd1;
            end else if (ph_new != PhOff && !ovr_q &&
                         int'(dwell_d) == expected_t(ph_new) + TOL + 1) begin
                // Overrun reported now; the exit check for this phase is then suppressed
                new_time = 1'b1;
                ovr_d    = 1'b1;
            end
        end
        seq_d   = (seq_q  & ~bus.clr) | new_seq;
        time_d  = (time_q & ~bus.clr) | new_time;
        code_d  = (code_q & ~bus.clr) | new_code;
        pulse_d = new_seq | new_time | new_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSync;
            phase_q <= PhOff;
            dwell_q <= '0;
            ovr_q   <= 1'b0;
            cycle_q <= 8'd0;
            seq_q   <= 1'b0;
            time_q  <= 1'b0;
            code_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            ovr_q   <= ovr_d;
            cycle_q <= cycle_d;
            seq_q   <= seq_d;
            time_q  <= time_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.phase_o     = phase_q;
    assign bus.err_seq     = seq_q;
    assign bus.err_time    = time_q;
    assign bus.err_code    = code_q;
    assign bus.err_pulse   = pulse_q;
    assign bus.cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: walks nominal cycles, timing faults, bad successions,
// illegal codes, clear/error priority and asynchronous reset with hand-computed expectations.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_RY  = 3'b110;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_BAD = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    traffic_light_monitor_if bus_if ();

    traffic_light_monitor #(
        .TIME_RED    (30),
        .TIME_YELLOW (3),
        .TIME_GREEN  (20),
        .TOL         (1),
        .CW          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic s, input logic t, input logic c);
        check({tag, ".err_seq"},  {7'd0, bus_if.err_seq},  {7'd0, s});
        check({tag, ".err_time"}, {7'd0, bus_if.err_time}, {7'd0, t});
        check({tag, ".err_code"}, {7'd0, bus_if.err_code}, {7'd0, c});
    endtask

    // One idle clk, then a single tick edge; returns 1 time unit after that edge.
    task automatic tick_in(input logic [2:0] l, input logic c);
        @(posedge clk);
        @(negedge clk);
        bus_if.light_i = l;
        bus_if.tick    = 1'b1;
        bus_if.clr     = c;
        @(posedge clk);
        #1;
        bus_if.tick = 1'b0;
        bus_if.clr  = 1'b0;
    endtask

    task automatic run(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) tick_in(l, 1'b0);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        bus_if.clr = 1'b1;
        @(posedge clk);
        #1;
        bus_if.clr = 1'b0;
    endtask

    initial begin
        bus_if.tick    = 1'b0;
        bus_if.light_i = L_OFF;
        bus_if.clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.phase", {5'd0, bus_if.phase_o}, 8'd0);
        check("rst.cycle", bus_if.cycle_count, 8'd0);
        check("rst.pulse", {7'd0, bus_if.err_pulse}, 8'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal cycles
        run(L_OFF, 2);
        check("nom.off", {5'd0, bus_if.phase_o}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            run(L_R, 1);
            check($sformatf("nom.r%0d", i), {5'd0, bus_if.phase_o}, 8'd1);
            run(L_R, 30);
            run(L_RY, 3);
            check($sformatf("nom.ry%0d", i), {5'd0, bus_if.phase_o}, 8'd2);
            run(L_G, 20);
            check($sformatf("nom.g%0d", i), {5'd0, bus_if.phase_o}, 8'd3);
            run(L_Y, 3);
            check($sformatf("nom.y%0d", i), {5'd0, bus_if.phase_o}, 8'd4);
            check($sformatf("nom.cyc%0d", i), bus_if.cycle_count, 8'(i));
        end
        run(L_R, 31);
        check("nom.cycle", bus_if.cycle_count, 8'd3);
        check_flags("nom", 1'b0, 1'b0, 1'b0);

        // Short red: 27 ticks of R
        run(L_RY, 3);
        run(L_G, 20);
        run(L_Y, 3);
        run(L_R, 27);
        check_flags("short.pre", 1'b0, 1'b0, 1'b0);
        tick_in(L_RY, 1'b0);
        check_flags("short", 1'b0, 1'b1, 1'b0);
        check("short.pulse", {7'd0, bus_if.err_pulse}, 8'd1);
        @(posedge clk);
        #1;
        check("short.pulse_drop", {7'd0, bus_if.err_pulse}, 8'd0);
        check("short.cycle", bus_if.cycle_count, 8'd4);
        clear_flags();
        check_flags("short.clr", 1'b0, 1'b0, 1'b0);

        // Stuck green: overrun on the 22nd tick, silent exit at tick 40
        run(L_RY, 2);
        run(L_G, 21);
        check_flags("stuck.21", 1'b0, 1'b0, 1'b0);
        tick_in(L_G, 1'b0);
        check_flags("stuck.22", 1'b0, 1'b1, 1'b0);
        check("stuck.pulse", {7'd0, bus_if.err_pulse}, 8'd1);
        clear_flags();
        run(L_G, 18);
        check("stuck.late", {7'd0, bus_if.err_time}, 8'd0);
        tick_in(L_Y, 1'b0);
        check_flags("stuck.exit", 1'b0, 1'b0, 1'b0);
        check("stuck.exit_pulse", {7'd0, bus_if.err_pulse}, 8'd0);
        run(L_Y, 2);

        // Bad succession R -> G
        run(L_R, 30);
        check("bad.cycle5", bus_if.cycle_count, 8'd5);
        tick_in(L_G, 1'b0);
        check_flags("bad", 1'b1, 1'b0, 1'b0);
        check("bad.pulse", {7'd0, bus_if.err_pulse}, 8'd1);
        run(L_G, 19);
        run(L_Y, 3);
        tick_in(L_R, 1'b0);
        check_flags("bad.after", 1'b1, 1'b0, 1'b0);
        check("bad.after_pulse", {7'd0, bus_if.err_pulse}, 8'd0);
        check("bad.cycle6", bus_if.cycle_count, 8'd6);
        clear_flags();

        // Illegal code mid-RY, resync on R, next RY checked normally
        run(L_R, 30);
        tick_in(L_RY, 1'b0);
        tick_in(L_BAD, 1'b0);
        check("ill.phase", {5'd0, bus_if.phase_o}, 8'd7);
        check_flags("ill", 1'b0, 1'b0, 1'b1);
        check("ill.pulse", {7'd0, bus_if.err_pulse}, 8'd1);
        run(L_R, 31);
        check_flags("ill.resync", 1'b0, 1'b0, 1'b1);
        check("ill.resync_phase", {5'd0, bus_if.phase_o}, 8'd1);
        tick_in(L_RY, 1'b0);
        check_flags("ill.ry1", 1'b0, 1'b0, 1'b1);
        run(L_RY, 3);
        check("ill.ry4", {7'd0, bus_if.err_time}, 8'd0);
        tick_in(L_RY, 1'b0);
        check("ill.ry5", {7'd0, bus_if.err_time}, 8'd1);
        check("ill.cycle", bus_if.cycle_count, 8'd6);

        // clr coinciding with a new err_seq, then clr alone
        clear_flags();
        check_flags("clr.pre", 1'b0, 1'b0, 1'b0);
        tick_in(L_Y, 1'b1);
        check_flags("clr.same", 1'b1, 1'b0, 1'b0);
        clear_flags();
        check_flags("clr.alone", 1'b0, 1'b0, 1'b0);
        check("clr.cycle", bus_if.cycle_count, 8'd6);

        // Asynchronous reset mid-G
        run(L_Y, 2);
        tick_in(L_G, 1'b0);
        run(L_G, 5);
        check("arst.pre_seq", {7'd0, bus_if.err_seq}, 8'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst.phase", {5'd0, bus_if.phase_o}, 8'd0);
        check("arst.cycle", bus_if.cycle_count, 8'd0);
        check("arst.pulse", {7'd0, bus_if.err_pulse}, 8'd0);
        check_flags("arst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run(L_OFF, 2);
        run(L_R, 30);
        check("arst.track", {5'd0, bus_if.phase_o}, 8'd1);
        check_flags("arst.track", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
